// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, mid-bit sampling, glitch/break handling, valid/ack handshake.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
`timescale 1ns/1ps
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 20,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] dataout,
  output logic                 Done,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t               state, state_n;
  logic                 rx_m, rx_s;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] sr;
  logic                 stop_seen, stop_bit;
  logic                 cnt_clr, smp, deliver;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_clr = 1'b0;
    smp     = 1'b0;
    deliver = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        cnt_clr = 1'b1;
      end
      START: if (cnt == HALF) begin
        smp     = 1'b1;
        cnt_clr = 1'b1;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == FULL) begin
        smp = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (idx == LAST) state_n = PARITY;
`else
        if (idx == LAST) state_n = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt == FULL) begin
        smp     = 1'b1;
        state_n = STOP;
      end
`endif
      // Stop bit is sampled one clock before the frame is delivered.
      STOP: begin
        if (stop_seen) begin
          deliver = 1'b1;
          state_n = stop_bit ? IDLE : BREAK;
        end else if (cnt == FULL) begin
          smp = 1'b1;
        end
      end
      BREAK: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      sr         <= '0;
      stop_seen  <= 1'b0;
      stop_bit   <= 1'b1;
      tick       <= 1'b0;
      Done       <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      dataout    <= '0;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
`endif
    end else begin
      cnt       <= (cnt_clr || cnt == FULL) ? '0 : cnt + 1'b1;
      tick      <= smp;
      stop_seen <= smp && (state == STOP);
      if (smp && state == STOP) stop_bit <= rx_s;
      if (smp && state == START) idx <= '0;
      if (smp && state == DATA) begin
        sr[idx] <= rx_s;
        idx     <= idx + 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      if (smp && state == PARITY) par_bad <= rx_s ^ (^sr) ^ (PARITY_ODD != 0);
      parity_err <= deliver & par_bad;
`else
      parity_err <= 1'b0;
`endif
      Done      <= deliver;
      frame_err <= deliver & ~stop_bit;
      if (deliver) dataout <= sr;
      // An ack landing with a new frame acknowledges the old one, so no overrun.
      if (deliver)     rx_valid <= 1'b1;
      else if (rx_ack) rx_valid <= 1'b0;
      if (rx_ack)                   overrun <= 1'b0;
      else if (deliver && rx_valid) overrun <= 1'b1;
    end
  end
endmodule
